// File: rtl/minicpu_pkg.sv
// Shared definitions for the multi-cycle LA32R mini core:
// opcode fields, decoded op set, FSM states and reset PC.
package minicpu_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;

  localparam logic [16:0] OPC_ADD_W  = 17'h00020;
  localparam logic [16:0] OPC_SUB_W  = 17'h00022;
  localparam logic [9:0]  OPC_ADDI_W = 10'h00a;
  localparam logic [9:0]  OPC_LD_W   = 10'h0a2;
  localparam logic [9:0]  OPC_ST_W   = 10'h0a6;
  localparam logic [5:0]  OPC_BEQ    = 6'h16;
  localparam logic [5:0]  OPC_BNE    = 6'h17;
  localparam logic [5:0]  OPC_B      = 6'h14;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL,
    OP_ADD,
    OP_SUB,
    OP_ADDI,
    OP_LD,
    OP_ST,
    OP_BEQ,
    OP_BNE,
    OP_B
  } op_e;

  // Classify by inst[31:15]; the opcode widths nest so one slice suffices.
  function automatic op_e decode_op(input logic [16:0] hi);
    op_e op;
    op = OP_ILL;
    unique case (1'b1)
      hi == OPC_ADD_W:       op = OP_ADD;
      hi == OPC_SUB_W:       op = OP_SUB;
      hi[16:7] == OPC_ADDI_W: op = OP_ADDI;
      hi[16:7] == OPC_LD_W:   op = OP_LD;
      hi[16:7] == OPC_ST_W:   op = OP_ST;
      hi[16:11] == OPC_BEQ:   op = OP_BEQ;
      hi[16:11] == OPC_BNE:   op = OP_BNE;
      hi[16:11] == OPC_B:     op = OP_B;
      default:               op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/minicpu_multicycle_if.sv
// Instruction and data SRAM ports of the mini core.
// req is held until rvalid; address/data are stable while req.
interface minicpu_multicycle_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_rvalid,
    input  inst_rdata,
    output data_req,
    output data_we,
    output data_addr,
    output data_wdata,
    input  data_rvalid,
    input  data_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_rvalid,
    output inst_rdata,
    input  data_req,
    input  data_we,
    input  data_addr,
    input  data_wdata,
    output data_rvalid,
    output data_rdata
  );

endinterface

// File: rtl/minicpu_multicycle_regfile.sv
// 32x32 GPR file, two async reads and one sync write.
// r0 always reads zero and ignores writes.
module minicpu_multicycle_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] rf [32];

  // Write port; r0 is never stored.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

// File: rtl/minicpu_multicycle.sv
// Multi-cycle LA32R core: one FSM walks FETCH/DECODE/EXEC/MEM/WB.
// Stops in HALT on an illegal opcode; exposes a retire trace.
module minicpu_multicycle
  import minicpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter bit          HALT_ON_ILL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  minicpu_multicycle_if.master bus,
  output logic                 halted,
  output logic [31:0]          debug_wb_pc,
  output logic                 debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  state_e      state;
  op_e         op;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] res;

  logic        inst_req_q;
  logic        data_req_q;
  logic        data_we_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;

  logic [4:0]  rd;
  logic [4:0]  rj;
  logic [4:0]  rk;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        use_rd;
  logic        rf_we;

  logic [31:0] simm12;
  logic [31:0] br_offs;
  logic [31:0] src2;
  logic [31:0] alu;
  logic [31:0] pc_seq;
  logic        taken;

  assign rd = ir[4:0];
  assign rj = ir[9:5];
  assign rk = ir[14:10];
  assign op = decode_op(ir[31:15]);

  // Stores and compare-branches read rd as the second source.
  assign use_rd = (op == OP_ST) || (op == OP_BEQ) || (op == OP_BNE);
  assign raddr2 = use_rd ? rd : rk;
  assign rf_we  = (state == S_WB);

  assign simm12 = {{20{ir[21]}}, ir[21:10]};
  assign br_offs = (op == OP_B)
    ? {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00}
    : {{14{ir[25]}}, ir[25:10], 2'b00};

  assign src2   = (op == OP_ADD) ? opb : simm12;
  assign alu    = (op == OP_SUB) ? (opa - opb) : (opa + src2);
  assign pc_seq = pc + 32'd4;

  // Branch condition from the latched operands.
  always_comb begin
    taken = 1'b0;
    unique case (op)
      OP_BEQ:  taken = (opa == opb);
      OP_BNE:  taken = (opa != opb);
      OP_B:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  minicpu_multicycle_regfile u_rf (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (res)
  );

  assign bus.inst_req   = inst_req_q;
  assign bus.inst_addr  = pc;
  assign bus.data_req   = data_req_q;
  assign bus.data_we    = data_we_q;
  assign bus.data_addr  = data_addr_q;
  assign bus.data_wdata = data_wdata_q;

  // Main FSM; every output is a register, debug_wb_* pulses one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_FETCH;
      pc                <= RESET_PC;
      ir                <= '0;
      opa               <= '0;
      opb               <= '0;
      res               <= '0;
      inst_req_q        <= 1'b0;
      data_req_q        <= 1'b0;
      data_we_q         <= 1'b0;
      data_addr_q       <= '0;
      data_wdata_q      <= '0;
      halted            <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= 1'b0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= 1'b0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      unique case (state)
        S_FETCH: begin
          if (inst_req_q && bus.inst_rvalid) begin
            ir         <= bus.inst_rdata;
            inst_req_q <= 1'b0;
            state      <= S_DECODE;
          end else begin
            inst_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          opa <= rdata1;
          opb <= rdata2;
          if (op == OP_ILL) begin
            if (HALT_ON_ILL) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              debug_wb_pc <= pc;
              pc          <= pc_seq;
              inst_req_q  <= 1'b1;
              state       <= S_FETCH;
            end
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (op)
            OP_ADD, OP_SUB, OP_ADDI: begin
              res   <= alu;
              state <= S_WB;
            end
            OP_LD, OP_ST: begin
              data_addr_q  <= alu;
              data_wdata_q <= opb;
              data_we_q    <= (op == OP_ST);
              data_req_q   <= 1'b1;
              state        <= S_MEM;
            end
            OP_BEQ, OP_BNE, OP_B: begin
              debug_wb_pc <= pc;
              pc          <= taken ? (pc + br_offs) : pc_seq;
              inst_req_q  <= 1'b1;
              state       <= S_FETCH;
            end
            default: begin
              inst_req_q <= 1'b1;
              state      <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (data_req_q && bus.data_rvalid) begin
            data_req_q <= 1'b0;
            data_we_q  <= 1'b0;
            if (op == OP_LD) begin
              res   <= bus.data_rdata;
              state <= S_WB;
            end else begin
              debug_wb_pc <= pc;
              pc          <= pc_seq;
              inst_req_q  <= 1'b1;
              state       <= S_FETCH;
            end
          end
        end
        S_WB: begin
          debug_wb_pc       <= pc;
          debug_wb_rf_we    <= (rd != 5'd0);
          debug_wb_rf_wnum  <= (rd != 5'd0) ? rd : 5'd0;
          debug_wb_rf_wdata <= (rd != 5'd0) ? res : 32'd0;
          pc                <= pc_seq;
          inst_req_q        <= 1'b1;
          state             <= S_FETCH;
        end
        S_HALT: begin
          halted     <= 1'b1;
          inst_req_q <= 1'b0;
          data_req_q <= 1'b0;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minicpu_multicycle.sv
// Self-checking bench for minicpu_multicycle: SRAM responders,
// retire monitor and per-scenario scoreboards.
module tb_minicpu_multicycle;

  localparam logic [31:0] B      = 32'h1c00_0000;
  localparam logic [31:0] ADD_W  = 32'h0010_0000;
  localparam logic [31:0] SUB_W  = 32'h0011_0000;
  localparam logic [31:0] ADDI_W = 32'h0280_0000;
  localparam logic [31:0] LD_W   = 32'h2880_0000;
  localparam logic [31:0] ST_W   = 32'h2980_0000;
  localparam logic [31:0] BEQ    = 32'h5800_0000;
  localparam logic [31:0] BNE    = 32'h5c00_0000;
  localparam logic [31:0] ILL    = 32'hffff_ffff;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    int          cyc;
  } ret_t;

  typedef struct {
    logic [31:0] addr;
    int          start;
    int          len;
    bit          stable;
  } fetch_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halted;
  logic [31:0] dbg_pc;
  logic        dbg_we;
  logic [4:0]  dbg_wnum;
  logic [31:0] dbg_wdata;

  minicpu_multicycle_if bus ();

  minicpu_multicycle #(
    .RESET_PC    (B),
    .HALT_ON_ILL (1'b1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .halted            (halted),
    .debug_wb_pc       (dbg_pc),
    .debug_wb_rf_we    (dbg_we),
    .debug_wb_rf_wnum  (dbg_wnum),
    .debug_wb_rf_wdata (dbg_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int inst_wait = 0;
  int data_wait = 0;
  int icnt = 0;
  int dcnt = 0;
  bit late_dvalid = 1'b0;
  bit ireq_d = 1'b0;
  bit dreq_d = 1'b0;
  int dstable_bad = 0;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  ret_t   exp_q[$];
  ret_t   got_q[$];
  fetch_t fetch_q[$];
  dreq_t  dreq_q[$];
  fetch_t f_cur;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM responders: rvalid after a programmable number of req cycles.
  always @(negedge clk) begin
    if (bus.inst_req) begin
      bus.inst_rvalid = (icnt >= inst_wait);
      bus.inst_rdata = imem.exists(bus.inst_addr) ? imem[bus.inst_addr] : ILL;
      icnt++;
    end else begin
      bus.inst_rvalid = 1'b0;
      icnt = 0;
    end
    if (bus.data_req) begin
      bus.data_rvalid = (dcnt >= data_wait);
      bus.data_rdata = dmem.exists(bus.data_addr) ? dmem[bus.data_addr] : 32'd0;
      if (bus.data_rvalid && bus.data_we) dmem[bus.data_addr] = bus.data_wdata;
      dcnt++;
    end else begin
      bus.data_rvalid = 1'b0;
      dcnt = 0;
    end
    if (late_dvalid) bus.data_rvalid = 1'b1;
  end

  // Monitor: retire trace, fetch request spans, data requests.
  always @(negedge clk) begin
    if (dbg_pc != 32'd0 || dbg_we) begin
      got_q.push_back('{dbg_pc, dbg_we, dbg_wnum, dbg_wdata, cyc});
    end
    if (bus.inst_req && !ireq_d) f_cur = '{bus.inst_addr, cyc, 0, 1'b1};
    if (bus.inst_req) begin
      f_cur.len++;
      if (bus.inst_addr != f_cur.addr) f_cur.stable = 1'b0;
    end
    if (!bus.inst_req && ireq_d) fetch_q.push_back(f_cur);
    ireq_d = bus.inst_req;
    if (bus.data_req && !dreq_d) begin
      dreq_q.push_back('{bus.data_we, bus.data_addr, bus.data_wdata});
    end else if (bus.data_req && dreq_q.size() > 0) begin
      if (bus.data_addr != dreq_q[$].addr || bus.data_we != dreq_q[$].we ||
          bus.data_wdata != dreq_q[$].wdata) dstable_bad++;
    end
    dreq_d = bus.data_req;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc_3r(input logic [31:0] base,
      input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk);
    return base | {17'd0, rk, rj, rd};
  endfunction

  function automatic logic [31:0] enc_i12(input logic [31:0] base,
      input logic [4:0] rd, input logic [4:0] rj, input logic [11:0] imm);
    return base | {10'd0, imm, rj, rd};
  endfunction

  function automatic logic [31:0] enc_br(input logic [31:0] base,
      input logic [4:0] rj, input logic [4:0] rd, input logic [31:0] offs);
    logic [15:0] o;
    o = offs[17:2];
    return base | {6'd0, o, rj, rd};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] offs);
    logic [25:0] o;
    o = offs[27:2];
    return 32'h5000_0000 | {6'd0, o[15:0], o[25:16]};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    imem[addr] = w;
  endtask

  task automatic expect_ret(input logic [31:0] pc, input logic we,
      input logic [4:0] wnum, input logic [31:0] wdata);
    exp_q.push_back('{pc, we, wnum, wdata, 0});
  endtask

  // Holds reset and clears all logs and memories; caller releases it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    late_dvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    fetch_q.delete();
    dreq_q.delete();
    imem.delete();
    dmem.delete();
    dstable_bad = 0;
  endtask

  task automatic wait_retires(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    put(B, ILL);
    n_tests++;
    if (bus.inst_req !== 1'b0 || bus.data_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: inst_req=%b data_req=%b want 0 0", bus.inst_req, bus.data_req);
    end
    n_tests++;
    if (halted !== 1'b0 || dbg_pc !== 32'd0 || dbg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: halted=%b dbg_pc=%h dbg_we=%b want 0", halted, dbg_pc, dbg_we);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== B) begin
      n_fail++;
      $display("FAIL reset_fetch: req=%b addr=%h want 1 %h", bus.inst_req, bus.inst_addr, B);
    end
  endtask

  task automatic test_alu();
    ret_t e;
    ret_t g;
    int cy[$];
    bit ok;
    do_reset();
    put(B,        enc_i12(ADDI_W, 5'd1, 5'd0, 12'd5));
    put(B + 4,    enc_i12(ADDI_W, 5'd2, 5'd0, 12'hffd));
    put(B + 8,    enc_3r(ADD_W, 5'd3, 5'd1, 5'd2));
    put(B + 12,   enc_3r(SUB_W, 5'd4, 5'd1, 5'd2));
    put(B + 16,   ILL);
    expect_ret(B,      1'b1, 5'd1, 32'd5);
    expect_ret(B + 4,  1'b1, 5'd2, 32'hffff_fffd);
    expect_ret(B + 8,  1'b1, 5'd3, 32'd2);
    expect_ret(B + 12, 1'b1, 5'd4, 32'd8);
    reset = 1'b0;
    wait_retires(4, 100, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL alu_trace: missing retire, want pc=%h", e.pc);
      end else begin
        g = got_q.pop_front();
        cy.push_back(g.cyc);
        if (g.pc !== e.pc || g.we !== e.we || g.wnum !== e.wnum || g.wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL alu_trace: got pc=%h we=%b n=%0d d=%h want pc=%h we=%b n=%0d d=%h",
                   g.pc, g.we, g.wnum, g.wdata, e.pc, e.we, e.wnum, e.wdata);
        end
      end
    end
    for (int i = 1; i < cy.size(); i++) begin
      n_tests++;
      if (cy[i] - cy[i-1] != 4) begin
        n_fail++;
        $display("FAIL alu_latency[%0d]: got %0d cycles want 4", i, cy[i] - cy[i-1]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    ret_t e;
    ret_t g;
    int cy[$];
    bit ok;
    do_reset();
    inst_wait = 3;
    put(B,     enc_i12(ADDI_W, 5'd1, 5'd0, 12'd5));
    put(B + 4, enc_i12(ADDI_W, 5'd2, 5'd0, 12'hffd));
    put(B + 8, enc_3r(ADD_W, 5'd3, 5'd1, 5'd2));
    put(B + 12, ILL);
    expect_ret(B,     1'b1, 5'd1, 32'd5);
    expect_ret(B + 4, 1'b1, 5'd2, 32'hffff_fffd);
    expect_ret(B + 8, 1'b1, 5'd3, 32'd2);
    reset = 1'b0;
    wait_retires(3, 200, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL wait_trace: missing retire, want pc=%h", e.pc);
      end else begin
        g = got_q.pop_front();
        cy.push_back(g.cyc);
        if (g.pc !== e.pc || g.we !== e.we || g.wnum !== e.wnum || g.wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL wait_trace: got pc=%h n=%0d d=%h want pc=%h n=%0d d=%h",
                   g.pc, g.wnum, g.wdata, e.pc, e.wnum, e.wdata);
        end
      end
    end
    n_tests++;
    if (fetch_q.size() == 0 || fetch_q[0].len != 4 || !fetch_q[0].stable) begin
      n_fail++;
      $display("FAIL wait_req_hold: got %0d fetch records, first len/stable wrong, want len=4 stable",
               fetch_q.size());
    end
    n_tests++;
    if (cy.size() < 2 || cy[1] - cy[0] != 7) begin
      n_fail++;
      $display("FAIL wait_latency: got %0d retires, spacing wrong, want 7", cy.size());
    end
    inst_wait = 0;
  endtask

  task automatic test_ldst();
    ret_t e;
    ret_t g;
    int ld_cyc;
    int ld_fetch;
    bit ok;
    do_reset();
    data_wait = 2;
    put(B,      enc_i12(ADDI_W, 5'd1, 5'd0, 12'd5));
    put(B + 4,  enc_i12(ADDI_W, 5'd2, 5'd0, 12'hffd));
    put(B + 8,  enc_3r(ADD_W, 5'd3, 5'd1, 5'd2));
    put(B + 12, enc_i12(ST_W, 5'd3, 5'd0, 12'h010));
    put(B + 16, enc_i12(LD_W, 5'd5, 5'd0, 12'h010));
    put(B + 20, ILL);
    expect_ret(B,      1'b1, 5'd1, 32'd5);
    expect_ret(B + 4,  1'b1, 5'd2, 32'hffff_fffd);
    expect_ret(B + 8,  1'b1, 5'd3, 32'd2);
    expect_ret(B + 12, 1'b0, 5'd0, 32'd0);
    expect_ret(B + 16, 1'b1, 5'd5, 32'd2);
    reset = 1'b0;
    wait_retires(5, 200, ok);
    ld_cyc = -100;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL ldst_trace: missing retire, want pc=%h", e.pc);
      end else begin
        g = got_q.pop_front();
        if (g.pc == B + 16) ld_cyc = g.cyc;
        if (g.pc !== e.pc || g.we !== e.we || g.wnum !== e.wnum || g.wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL ldst_trace: got pc=%h we=%b n=%0d d=%h want pc=%h we=%b n=%0d d=%h",
                   g.pc, g.we, g.wnum, g.wdata, e.pc, e.we, e.wnum, e.wdata);
        end
      end
    end
    n_tests++;
    if (dreq_q.size() < 2) begin
      n_fail++;
      $display("FAIL ldst_reqs: got %0d data requests want 2", dreq_q.size());
    end else begin
      if (dreq_q[0].we !== 1'b1 || dreq_q[0].addr !== 32'h10 || dreq_q[0].wdata !== 32'd2) begin
        n_fail++;
        $display("FAIL st_req: got we=%b addr=%h wdata=%h want 1 00000010 00000002",
                 dreq_q[0].we, dreq_q[0].addr, dreq_q[0].wdata);
      end
      n_tests++;
      if (dreq_q[1].we !== 1'b0 || dreq_q[1].addr !== 32'h10) begin
        n_fail++;
        $display("FAIL ld_req: got we=%b addr=%h want 0 00000010", dreq_q[1].we, dreq_q[1].addr);
      end
    end
    n_tests++;
    if (dstable_bad != 0) begin
      n_fail++;
      $display("FAIL data_hold: got %0d unstable cycles want 0", dstable_bad);
    end
    ld_fetch = -1000;
    foreach (fetch_q[i]) if (fetch_q[i].addr == B + 16) ld_fetch = fetch_q[i].start;
    n_tests++;
    if (ld_cyc - ld_fetch != 7) begin
      n_fail++;
      $display("FAIL ld_latency: got %0d cycles want 7", ld_cyc - ld_fetch);
    end
    data_wait = 0;
  endtask

  task automatic test_branch();
    ret_t e;
    ret_t g;
    int cy[$];
    bit ok;
    do_reset();
    put(B,         enc_i12(ADDI_W, 5'd1, 5'd0, 12'd5));
    put(B + 4,     enc_i12(ADDI_W, 5'd2, 5'd0, 12'hffd));
    put(B + 8,     enc_br(BNE, 5'd1, 5'd2, 32'd8));
    put(B + 12,    enc_b(32'h100));
    put(B + 16,    enc_br(BEQ, 5'd1, 5'd1, 32'hffff_fffc));
    put(B + 32'h10c, enc_i12(ADDI_W, 5'd6, 5'd0, 12'd1));
    put(B + 32'h110, ILL);
    expect_ret(B,           1'b1, 5'd1, 32'd5);
    expect_ret(B + 4,       1'b1, 5'd2, 32'hffff_fffd);
    expect_ret(B + 8,       1'b0, 5'd0, 32'd0);
    expect_ret(B + 16,      1'b0, 5'd0, 32'd0);
    expect_ret(B + 12,      1'b0, 5'd0, 32'd0);
    expect_ret(B + 32'h10c, 1'b1, 5'd6, 32'd1);
    reset = 1'b0;
    wait_retires(6, 200, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL br_trace: missing retire, want pc=%h", e.pc);
      end else begin
        g = got_q.pop_front();
        cy.push_back(g.cyc);
        if (g.pc !== e.pc || g.we !== e.we || g.wnum !== e.wnum || g.wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL br_trace: got pc=%h we=%b n=%0d d=%h want pc=%h we=%b n=%0d d=%h",
                   g.pc, g.we, g.wnum, g.wdata, e.pc, e.we, e.wnum, e.wdata);
        end
      end
    end
    n_tests++;
    if (cy.size() < 5 || cy[3] - cy[2] != 3 || cy[4] - cy[3] != 3) begin
      n_fail++;
      $display("FAIL br_latency: got %0d retires or spacing not 3, want 3", cy.size());
    end
  endtask

  task automatic test_r0();
    ret_t e;
    ret_t g;
    bit ok;
    do_reset();
    put(B,     enc_i12(ADDI_W, 5'd0, 5'd0, 12'd7));
    put(B + 4, enc_3r(ADD_W, 5'd7, 5'd0, 5'd0));
    put(B + 8, ILL);
    expect_ret(B,     1'b0, 5'd0, 32'd0);
    expect_ret(B + 4, 1'b1, 5'd7, 32'd0);
    reset = 1'b0;
    wait_retires(2, 100, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL r0_trace: missing retire, want pc=%h", e.pc);
      end else begin
        g = got_q.pop_front();
        if (g.pc !== e.pc || g.we !== e.we || g.wnum !== e.wnum || g.wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL r0_trace: got pc=%h we=%b n=%0d d=%h want pc=%h we=%b n=%0d d=%h",
                   g.pc, g.we, g.wnum, g.wdata, e.pc, e.we, e.wnum, e.wdata);
        end
      end
    end
  endtask

  task automatic test_halt();
    int req_seen;
    int low_halt;
    bit seen;
    do_reset();
    put(B,     enc_i12(ADDI_W, 5'd1, 5'd0, 12'd9));
    put(B + 4, ILL);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (halted === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL halt_set: got halted=%b want 1 within 40 cycles", halted);
    end
    req_seen = 0;
    low_halt = 0;
    got_q.delete();
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.inst_req || bus.data_req) req_seen++;
      if (halted !== 1'b1) low_halt++;
    end
    n_tests++;
    if (req_seen != 0) begin
      n_fail++;
      $display("FAIL halt_noreq: got %0d req cycles want 0", req_seen);
    end
    n_tests++;
    if (low_halt != 0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_hold: got %0d low cycles, %0d retires want 0 0", low_halt, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ret_t g;
    bit ok;
    bit seen;
    do_reset();
    data_wait = 20;
    put(B,     enc_i12(ST_W, 5'd0, 5'd0, 12'h020));
    put(B + 4, ILL);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (bus.data_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_dreq: got data_req=%b want 1 within 30 cycles", bus.data_req);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.data_req !== 1'b0 || bus.inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drop: got data_req=%b inst_req=%b want 0 0", bus.data_req, bus.inst_req);
    end
    got_q.delete();
    fetch_q.delete();
    dreq_q.delete();
    data_wait = 0;
    late_dvalid = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    late_dvalid = 1'b0;
    wait_retires(1, 60, ok);
    n_tests++;
    if (fetch_q.size() == 0 || fetch_q[0].addr !== B) begin
      n_fail++;
      $display("FAIL mid_refetch: got %0d fetches, first addr wrong, want %h", fetch_q.size(), B);
    end
    n_tests++;
    if (got_q.size() == 0) begin
      n_fail++;
      $display("FAIL mid_retire: got no retire want pc=%h", B);
    end else begin
      g = got_q.pop_front();
      if (g.pc !== B || g.we !== 1'b0 || dreq_q.size() != 1) begin
        n_fail++;
        $display("FAIL mid_retire: got pc=%h we=%b dreqs=%0d want %h 0 1", g.pc, g.we, dreq_q.size(), B);
      end
    end
  endtask

  initial begin
    bus.inst_rvalid = 1'b0;
    bus.inst_rdata  = '0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = '0;
    test_reset();
    test_alu();
    test_fetch_wait();
    test_ldst();
    test_branch();
    test_r0();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
